// File: rtl/sync_fifo_lvl.sv
// rtl/sync_fifo_lvl.sv - single-clock FWFT FIFO with fill level, almost flags, flush and sticky errors
module sync_fifo_lvl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_flush,
    input  logic                  i_clr_err,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L   = (ADDR_WIDTH + 1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L  = (ADDR_WIDTH + 1)'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH:0] PTR_ZERO  = '0;

    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $fatal(1, "sync_fifo_lvl: ADDR_WIDTH must be >= 1");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $fatal(1, "sync_fifo_lvl: AFULL_LVL must lie in 1..depth");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_bad_aempty
        $fatal(1, "sync_fifo_lvl: AEMPTY_LVL must lie in 0..depth-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic rd_ok;
    logic wr_ok;
    logic wr_en;
    logic rd_en;

    // A write on a full FIFO is only safe when the head slot is vacated this cycle.
    assign rd_ok = i_rd & ~empty_q;
    assign wr_ok = i_wr & (~full_q | rd_ok);
    assign wr_en = wr_ok & ~i_flush;
    assign rd_en = rd_ok & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            level_d  = PTR_ZERO;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                2'b01:   level_d = level_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
                default: level_d = level_q;
            endcase
        end
    end

    // Flags come from the next level so they never trail o_level by a cycle.
    always_comb begin
        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == PTR_ZERO);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
    end

    // A rejection in the same cycle as i_clr_err keeps the flag set.
    always_comb begin
        ovf_d = (i_wr & ~wr_ok & ~i_flush) | (ovf_q & ~i_clr_err);
        udf_d = (i_rd & ~rd_ok & ~i_flush) | (udf_q & ~i_clr_err);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign o_data   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign o_full   = full_q;
    assign o_empty  = empty_q;
    assign o_afull  = afull_q;
    assign o_aempty = aempty_q;
    assign o_level  = level_q;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb/tb_sync_fifo_lvl.sv - scoreboard bench for sync_fifo_lvl with directed vectors
module tb_sync_fifo_lvl;

    logic       i_clk;
    logic       i_arst_n;
    logic       i_flush;
    logic       i_clr_err;
    logic       i_wr;
    logic [7:0] i_data;
    logic       i_rd;
    logic [7:0] o_data;
    logic       o_full;
    logic       o_empty;
    logic       o_afull;
    logic       o_aempty;
    logic [3:0] o_level;
    logic       o_ovf;
    logic       o_udf;

    int vectors;
    int miscompares;
    logic [7:0] exp_q [$];

    sync_fifo_lvl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AFULL_LVL (6),
        .AEMPTY_LVL(1)
    ) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_flush  (i_flush),
        .i_clr_err(i_clr_err),
        .i_wr     (i_wr),
        .i_data   (i_data),
        .i_rd     (i_rd),
        .o_data   (o_data),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .o_afull  (o_afull),
        .o_aempty (o_aempty),
        .o_level  (o_level),
        .o_ovf    (o_ovf),
        .o_udf    (o_udf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Popped data is checked whenever the DUT accepts a read.
    always @(negedge i_clk) begin
        if (i_arst_n && !i_flush && i_rd && !o_empty) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read at %0t", o_data, $time);
            end else begin
                chk("rd_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic flags(input int lvl, input logic ovf, input logic udf);
        chk("level",  {28'd0, o_level}, lvl);
        chk("empty",  {31'd0, o_empty},  {31'd0, lvl == 0});
        chk("full",   {31'd0, o_full},   {31'd0, lvl == 8});
        chk("afull",  {31'd0, o_afull},  {31'd0, lvl >= 6});
        chk("aempty", {31'd0, o_aempty}, {31'd0, lvl <= 1});
        chk("ovf",    {31'd0, o_ovf},    {31'd0, ovf});
        chk("udf",    {31'd0, o_udf},    {31'd0, udf});
    endtask

    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr);
        i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        i_arst_n = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
        i_wr = 1'b0; i_rd = 1'b0; i_data = 8'h00;
        #12;
        flags(0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            flags(i, 1'b0, 1'b0);
        end
        cyc(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        flags(8, 1'b1, 1'b0);

        // Write-through on full: head 0x01 leaves, 0xAA fills its slot.
        chk("head_full", {24'd0, o_data}, 32'h01);
        exp_q.push_back(8'hAA);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        flags(8, 1'b1, 1'b0);
        chk("head_after_wt", {24'd0, o_data}, 32'h02);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            flags(8 - k, 1'b1, 1'b0);
        end

        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        flags(0, 1'b0, 1'b0);
        exp_q.push_back(8'h5C);
        cyc(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        flags(1, 1'b0, 1'b1);
        chk("head_5c", {24'd0, o_data}, 32'h5C);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        flags(1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        flags(0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        end
        flags(3, 1'b0, 1'b0);
        for (int i = 3; i < 23; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        end
        flags(3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        flags(0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        end
        flags(5, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        flags(0, 1'b0, 1'b0);
        exp_q.push_back(8'h77);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        flags(1, 1'b0, 1'b0);
        chk("head_77", {24'd0, o_data}, 32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        flags(0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        flags(0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        end
        flags(4, 1'b0, 1'b1);
        #1;
        i_arst_n = 1'b0;
        #1;
        flags(0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;
        exp_q.push_back(8'h33);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        flags(1, 1'b0, 1'b0);
        chk("head_33", {24'd0, o_data}, 32'h33);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        flags(0, 1'b0, 1'b0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
